// File: rtl/gravity_lock_ctrl.sv
// gravity_lock_ctrl: level-paced fall requests and bounded lock-delay scheduling for the active brick
module gravity_lock_ctrl #(
  parameter int LEVEL_LEN = 4,
  parameter int CNT_W = 24,
  parameter logic [CNT_W-1:0] BASE_PERIOD = 24'd6000000,
  parameter logic [CNT_W-1:0] STEP = 24'd350000,
  parameter logic [CNT_W-1:0] MIN_PERIOD = 24'd400000,
  parameter logic [CNT_W-1:0] LOCK_TICKS = 24'd3000000,
  parameter int MAX_RESETS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic [LEVEL_LEN-1:0] level,
  input  logic fall_done,
  input  logic fall_blocked,
  input  logic move_ok,
  input  logic hard_drop,
  input  logic place_ack,
  input  logic piece_new,
  output logic fall_req,
  output logic place_req,
  output logic lock_active,
  output logic [3:0] resets_left
);
  typedef enum logic [2:0] {IDLE, FALLING, FALL_REQ, LOCKING, PLACE_REQ, SPAWN_WAIT} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, lock_cnt, lock_cnt_n, period_q, period, prod;
  logic [CNT_W:0] sum;
  logic [3:0] resets_n;
  always_comb begin
    prod = CNT_W'(level) * STEP;
    sum = {1'b0, prod} + {1'b0, MIN_PERIOD};
    period = (sum > {1'b0, BASE_PERIOD}) ? MIN_PERIOD : BASE_PERIOD - prod;
  end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    lock_cnt_n = lock_cnt;
    resets_n = resets_left;
    if (!enable) begin
      state_n = IDLE;
      cnt_n = '0;
      lock_cnt_n = '0;
    end else begin
      case (state)
        IDLE: begin
          state_n = FALLING;
          cnt_n = '0;
        end
        FALLING: begin
          cnt_n = cnt + CNT_W'(1);
          if (hard_drop) state_n = PLACE_REQ;
          else if (piece_new) begin
            cnt_n = '0;
            resets_n = 4'(MAX_RESETS);
          end else if (cnt == period_q - CNT_W'(1)) state_n = FALL_REQ;
        end
        FALL_REQ: if (fall_done) begin
          state_n = fall_blocked ? LOCKING : FALLING;
          cnt_n = '0;
          lock_cnt_n = '0;
        end
        LOCKING: begin
          lock_cnt_n = lock_cnt + CNT_W'(1);
          if (hard_drop) state_n = PLACE_REQ;
          else if (piece_new) begin
            state_n = FALLING;
            cnt_n = '0;
            resets_n = 4'(MAX_RESETS);
          end else if (move_ok && resets_left != 4'd0) begin
            state_n = FALLING;
            cnt_n = '0;
            resets_n = resets_left - 4'd1;
          end else if (lock_cnt == LOCK_TICKS - CNT_W'(1)) state_n = PLACE_REQ;
        end
        PLACE_REQ: state_n = place_ack ? SPAWN_WAIT : PLACE_REQ;
        SPAWN_WAIT: if (piece_new) begin
          state_n = FALLING;
          cnt_n = '0;
          resets_n = 4'(MAX_RESETS);
        end
        default: state_n = IDLE;
      endcase
    end
  end
  // outputs are decoded from next state so they appear in the same cycle as the new state
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      lock_cnt <= '0;
      period_q <= BASE_PERIOD;
      resets_left <= 4'(MAX_RESETS);
      fall_req <= 1'b0;
      place_req <= 1'b0;
      lock_active <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      lock_cnt <= lock_cnt_n;
      resets_left <= resets_n;
      fall_req <= state_n == FALL_REQ;
      place_req <= state_n == PLACE_REQ;
      lock_active <= state_n == LOCKING;
      if (state_n == FALLING && state != FALLING) period_q <= period;
    end
  end
endmodule

// File: tb/tb_gravity_lock_ctrl.sv
// tb_gravity_lock_ctrl: directed vectors, corner sequences and a randomized run against a deadline-based model
module tb_gravity_lock_ctrl;
  localparam int BP = 20, ST = 2, MP = 4, LT = 8, MR = 2;
  localparam int M_IDLE = 0, M_FALL = 1, M_FREQ = 2, M_LOCK = 3, M_PLACE = 4, M_SPAWN = 5;
  logic clk = 1'b0, rst = 1'b0, enable = 1'b0;
  logic fall_done = 1'b0, fall_blocked = 1'b0, move_ok = 1'b0, hard_drop = 1'b0, place_ack = 1'b0, piece_new = 1'b0;
  logic [3:0] level = 4'd0;
  logic fall_req, place_req, lock_active;
  logic [3:0] resets_left;
  int pass_cnt = 0, total = 0;
  typedef struct {logic [3:0] lvl; int cyc;} fall_vec_t;
  fall_vec_t tbl[7];
  gravity_lock_ctrl #(
    .LEVEL_LEN(4), .CNT_W(24), .BASE_PERIOD(24'(BP)), .STEP(24'(ST)),
    .MIN_PERIOD(24'(MP)), .LOCK_TICKS(24'(LT)), .MAX_RESETS(MR)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .level(level),
    .fall_done(fall_done), .fall_blocked(fall_blocked), .move_ok(move_ok),
    .hard_drop(hard_drop), .place_ack(place_ack), .piece_new(piece_new),
    .fall_req(fall_req), .place_req(place_req), .lock_active(lock_active),
    .resets_left(resets_left)
  );
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic clear_pulses;
    fall_done = 1'b0;
    move_ok = 1'b0;
    hard_drop = 1'b0;
    place_ack = 1'b0;
    piece_new = 1'b0;
  endtask
  task automatic do_reset;
    rst = 1'b0;
    enable = 1'b0;
    clear_pulses();
    repeat (3) tick();
    rst = 1'b1;
  endtask
  function automatic logic sig(input int s);
    return s == 0 ? fall_req : s == 1 ? place_req : lock_active;
  endfunction
  // counts edges (first edge samples any pulse set beforehand) until the selected output is high
  task automatic wait_sig(input int s, input int max, output int n);
    n = 0;
    do begin
      tick();
      clear_pulses();
      n++;
    end while (!sig(s) && n < max);
    if (!sig(s)) n = -1;
  endtask
  task automatic blocked_fall;
    fall_done = 1'b1;
    fall_blocked = 1'b1;
    tick();
    clear_pulses();
    fall_blocked = 1'b0;
  endtask
  function automatic int per_of(input int l);
    int p;
    p = l * ST;
    return (p + MP > BP) ? MP : BP - p;
  endfunction
  int n, m, t, mode, fall_due, lock_due, per_q, resets;
  bit saw_place;
  task automatic enter_fall;
    mode = M_FALL;
    per_q = per_of(int'(level));
    fall_due = t + per_q;
  endtask
  task automatic model_step;
    t++;
    if (!rst) begin
      mode = M_IDLE;
      resets = MR;
      per_q = BP;
    end else if (!enable) mode = M_IDLE;
    else begin
      case (mode)
        M_IDLE: enter_fall();
        M_FALL: if (hard_drop) mode = M_PLACE;
          else if (piece_new) begin
            fall_due = t + per_q;
            resets = MR;
          end else if (t == fall_due) mode = M_FREQ;
        M_FREQ: if (fall_done) begin
            if (fall_blocked) begin
              mode = M_LOCK;
              lock_due = t + LT;
            end else enter_fall();
          end
        M_LOCK: if (hard_drop) mode = M_PLACE;
          else if (piece_new) begin
            enter_fall();
            resets = MR;
          end else if (move_ok && resets > 0) begin
            enter_fall();
            resets--;
          end else if (t == lock_due) mode = M_PLACE;
        M_PLACE: if (place_ack) mode = M_SPAWN;
        default: if (piece_new) begin
            enter_fall();
            resets = MR;
          end
      endcase
    end
  endtask
  initial begin
    tbl[0] = '{4'd0, 21};
    tbl[1] = '{4'd1, 19};
    tbl[2] = '{4'd3, 15};
    tbl[3] = '{4'd7, 7};
    tbl[4] = '{4'd8, 5};
    tbl[5] = '{4'd9, 5};
    tbl[6] = '{4'd15, 5};
    do_reset();
    check("rst_fall_req", int'(fall_req), 0);
    check("rst_place_req", int'(place_req), 0);
    check("rst_lock_active", int'(lock_active), 0);
    check("rst_resets_left", int'(resets_left), MR);
    for (int i = 0; i < 7; i++) begin
      do_reset();
      level = tbl[i].lvl;
      enable = 1'b1;
      wait_sig(0, 100, n);
      check($sformatf("fall_period_lvl%0d", tbl[i].lvl), n, tbl[i].cyc);
    end
    do_reset();
    level = 4'd0;
    enable = 1'b1;
    wait_sig(0, 100, n);
    check("lvl0_first_fall", n, 21);
    fall_done = 1'b1;
    tick();
    clear_pulses();
    check("fall_req_drop", int'(fall_req), 0);
    wait_sig(0, 100, n);
    check("lvl0_refall", n + 1, 21);
    level = 4'd15;
    blocked_fall();
    check("lock_active_rise", int'(lock_active), 1);
    check("fall_req_clear_on_lock", int'(fall_req), 0);
    wait_sig(1, 50, n);
    check("lock_expiry", n + 1, 9);
    check("lock_active_at_place", int'(lock_active), 0);
    check("no_fall_with_place", int'(fall_req), 0);
    place_ack = 1'b1;
    tick();
    clear_pulses();
    check("place_ack_clear", int'(place_req), 0);
    piece_new = 1'b1;
    wait_sig(0, 50, n);
    check("lvl15_fall_after_spawn", n, 5);
    blocked_fall();
    tick();
    move_ok = 1'b1;
    tick();
    clear_pulses();
    check("reset1_resets_left", int'(resets_left), 1);
    check("reset1_lock_drop", int'(lock_active), 0);
    wait_sig(0, 50, n);
    check("reset1_refall", n + 1, 5);
    blocked_fall();
    move_ok = 1'b1;
    tick();
    clear_pulses();
    check("reset2_resets_left", int'(resets_left), 0);
    wait_sig(0, 50, n);
    blocked_fall();
    tick();
    move_ok = 1'b1;
    tick();
    clear_pulses();
    check("move_ignored_lock", int'(lock_active), 1);
    wait_sig(1, 50, m);
    check("lock_after_exhaust", 3 + m, 9);
    check("resets_saturate", int'(resets_left), 0);
    place_ack = 1'b1;
    tick();
    clear_pulses();
    piece_new = 1'b1;
    tick();
    clear_pulses();
    check("piece_new_restore", int'(resets_left), MR);
    wait_sig(0, 50, n);
    blocked_fall();
    hard_drop = 1'b1;
    move_ok = 1'b1;
    tick();
    clear_pulses();
    check("hd_beats_move", int'(place_req), 1);
    check("hd_keeps_resets", int'(resets_left), MR);
    level = 4'd0;
    place_ack = 1'b1;
    tick();
    clear_pulses();
    piece_new = 1'b1;
    wait_sig(0, 100, n);
    check("lvl0_after_spawn", n, 21);
    enable = 1'b0;
    tick();
    check("enable_drop", int'(fall_req), 0);
    tick();
    enable = 1'b1;
    wait_sig(0, 100, n);
    check("reenable_period", n, 21);
    blocked_fall();
    move_ok = 1'b1;
    tick();
    clear_pulses();
    hard_drop = 1'b1;
    tick();
    clear_pulses();
    check("hd_from_falling", int'(place_req), 1);
    check("pre_rst_resets", int'(resets_left), 1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("rst_mid_place_req", int'(place_req), 0);
    check("rst_mid_lock", int'(lock_active), 0);
    check("rst_mid_resets", int'(resets_left), MR);
    saw_place = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
      if (place_req) saw_place = 1'b1;
    end while (!fall_req && n < 100);
    check("post_rst_full_period", n, 21);
    check("post_rst_no_place", int'(saw_place), 0);
    rst = 1'b0;
    t = 0;
    for (int i = 0; i < 4000; i++) begin
      if (i > 0) begin
        rst = $urandom_range(0, 299) != 0;
        enable = $urandom_range(0, 99) != 0;
        if ($urandom_range(0, 49) == 0) level = 4'($urandom_range(0, 15));
        fall_done = $urandom_range(0, 2) == 0;
        fall_blocked = $urandom_range(0, 1) == 1;
        move_ok = $urandom_range(0, 5) == 0;
        hard_drop = $urandom_range(0, 39) == 0;
        place_ack = $urandom_range(0, 3) == 0;
        piece_new = $urandom_range(0, 29) == 0;
      end
      @(posedge clk);
      model_step();
      #1;
      check("rnd_fall_req", int'(fall_req), int'(mode == M_FREQ));
      check("rnd_place_req", int'(place_req), int'(mode == M_PLACE));
      check("rnd_lock_active", int'(lock_active), int'(mode == M_LOCK));
      check("rnd_resets_left", int'(resets_left), resets);
      check("rnd_exclusive", int'(fall_req & place_req), 0);
    end
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
